// File: rtl/aes_cipher.sv
// -----------------------------------------------------------------------------
// aes_cipher -- iterative AES-128 encryption core (FIPS-197).
//
// One round per clock, ten rounds per block. The initial AddRoundKey is
// folded into the load edge, so a block accepted on edge E0 completes on
// edge E10 and done pulses in the cycle that follows.
//
// Ports
//   clk          in   1    system clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   start        in   1    load plaintext/key on this edge when idle
//   plaintext    in   128  input block, byte0 = [127:120], column-major
//   key          in   128  cipher key, same byte order
//   cipher_text  out  128  ciphertext of the last completed block
//   keyout       out  128  round-10 key of the last completed block
//   busy         out  1    a block is in flight
//   done         out  1    one-cycle pulse: cipher_text/keyout just updated
//
// Handshake: start is a request, and busy is the inverse of ready. A block is
// accepted on any rising edge where start=1 and busy=0. Requests made while
// busy=1 are dropped, not queued. Because busy falls on the same edge that
// raises done, a start held high during the done cycle is accepted at once.
// This gives one block every 11 cycles.
// -----------------------------------------------------------------------------
module aes_cipher (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] cipher_text,
  output logic [127:0] keyout,
  output logic         busy,
  output logic         done
);

  typedef enum logic {ST_IDLE, ST_RUN} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] cipher_text_q, cipher_text_d;
  logic [127:0] keyout_q, keyout_d;
  logic         done_q, done_d;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial 0x11b
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; 0 maps to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, r;
    x2   = gf_mul(x, x);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    r    = gf_mul(x2, x4);
    r    = gf_mul(r, x8);
    r    = gf_mul(r, x16);
    r    = gf_mul(r, x32);
    r    = gf_mul(r, x64);
    r    = gf_mul(r, x128);
    return r;
  endfunction

  // S-box = affine transform of the field inverse.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // ---------------------------------------------------------------------------
  // Round transforms on the 128-bit state (byte i at [127-8i -: 8])
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One step of the key schedule: RotWord, SubWord, Rcon on the last word.
  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    t  = t ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [127:0] rk_nxt;
  logic [127:0] sr_out;

  always_comb begin
    rk_nxt = key_next(rk_q, rcon(round_q));
    sr_out = shift_rows(sub_bytes(state_q));
  end

  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    rk_d          = rk_q;
    round_d       = round_q;
    cipher_text_d = cipher_text_q;
    keyout_d      = keyout_q;
    done_d        = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = plaintext ^ key;
          rk_d    = key;
          round_d = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        rk_d = rk_nxt;
        if (round_q == 4'd10) begin
          // Final round skips MixColumns and publishes the result.
          cipher_text_d = sr_out ^ rk_nxt;
          keyout_d      = rk_nxt;
          done_d        = 1'b1;
          round_d       = 4'd0;
          fsm_d         = ST_IDLE;
        end else begin
          state_d = mix_columns(sr_out) ^ rk_nxt;
          round_d = round_q + 4'd1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q         <= ST_IDLE;
      state_q       <= '0;
      rk_q          <= '0;
      round_q       <= 4'd0;
      cipher_text_q <= '0;
      keyout_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      state_q       <= state_d;
      rk_q          <= rk_d;
      round_q       <= round_d;
      cipher_text_q <= cipher_text_d;
      keyout_q      <= keyout_d;
      done_q        <= done_d;
    end
  end

  assign cipher_text = cipher_text_q;
  assign keyout      = keyout_q;
  assign busy        = (fsm_q == ST_RUN);
  assign done        = done_q;

endmodule

// File: tb/tb_aes_cipher.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher -- directed and random checks of aes_cipher against FIPS-197
// vectors and a table-driven reference model.
// -----------------------------------------------------------------------------
module tb_aes_cipher;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] cipher_text;
  logic [127:0] keyout;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KO_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KO_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

  aes_cipher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .plaintext   (plaintext),
    .key         (key),
    .cipher_text (cipher_text),
    .keyout      (keyout),
    .busy        (busy),
    .done        (done)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX_TBL;
    return t[2047-8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] m_x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {ciphertext, round-10 key}.
  function automatic logic [255:0] m_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s, t, rk;
    logic [31:0]  w;
    logic [79:0]  rc_tbl;
    logic [7:0]   a0, a1, a2, a3;
    rc_tbl = RCON_TBL;
    s  = pt ^ k;
    rk = k;
    for (int r = 1; r <= 10; r++) begin
      w = {rk[23:0], rk[31:24]};
      w = {m_sbox(w[31:24]), m_sbox(w[23:16]), m_sbox(w[15:8]), m_sbox(w[7:0])};
      w = w ^ {rc_tbl[79-8*(r-1) -: 8], 24'h0};
      rk[127:96] = rk[127:96] ^ w;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[127-8*(4*c+rr) -: 8] = m_sbox(s[127-8*(4*((c+rr)%4)+rr) -: 8]);
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
          t[127-32*c -: 8] = m_x2(a0) ^ (m_x2(a1) ^ a1) ^ a2 ^ a3;
          t[119-32*c -: 8] = a0 ^ m_x2(a1) ^ (m_x2(a2) ^ a2) ^ a3;
          t[111-32*c -: 8] = a0 ^ a1 ^ m_x2(a2) ^ (m_x2(a3) ^ a3);
          t[103-32*c -: 8] = (m_x2(a0) ^ a0) ^ a1 ^ a2 ^ m_x2(a3);
        end
      end
      s = t ^ rk;
    end
    return {s, rk};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: loads one block and waits for done; lat=-1 on timeout
  // ---------------------------------------------------------------------------
  task automatic do_block(input logic [127:0] pt, input logic [127:0] k,
                          output logic [127:0] ct, output logic [127:0] ko,
                          output int lat);
    plaintext = pt;
    key       = k;
    start     = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    ct = cipher_text;
    ko = keyout;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; plaintext = '0; key = '0;
    tick(); tick();
    total++; if (cipher_text !== 128'h0) begin bad++; $display("FAIL reset_ct got=%h exp=0", cipher_text); end
    total++; if (keyout !== 128'h0) begin bad++; $display("FAIL reset_keyout got=%h exp=0", keyout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_app_b();
    logic [127:0] ct, ko;
    int lat;
    do_block(PT_B, K_B, ct, ko, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL appb_latency got=%0d exp=10", lat); end
    total++; if (ct !== CT_B) begin bad++; $display("FAIL appb_ct got=%h exp=%h", ct, CT_B); end
    total++; if (ko !== KO_B) begin bad++; $display("FAIL appb_keyout got=%h exp=%h", ko, KO_B); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL appb_busy_at_done got=%b exp=0", busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL appb_done_width got=%b exp=0", done); end
  endtask

  task automatic test_c1();
    logic [127:0] ct, ko;
    int lat;
    do_block(PT_C, K_C, ct, ko, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL c1_latency got=%0d exp=10", lat); end
    total++; if (ct !== CT_C) begin bad++; $display("FAIL c1_ct got=%h exp=%h", ct, CT_C); end
    total++; if (ko !== KO_C) begin bad++; $display("FAIL c1_keyout got=%h exp=%h", ko, KO_C); end
  endtask

  task automatic test_zero();
    logic [127:0] ct, ko;
    logic [255:0] m;
    int lat;
    m = m_enc(128'h0, 128'h0);
    do_block(128'h0, 128'h0, ct, ko, lat);
    total++; if (ct !== CT_Z) begin bad++; $display("FAIL zero_ct got=%h exp=%h", ct, CT_Z); end
    total++; if (ko !== m[127:0]) begin bad++; $display("FAIL zero_keyout got=%h exp=%h", ko, m[127:0]); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct1, ct2, ko2;
    int first, second;
    first = -1; second = -1;
    ct1 = '0; ct2 = '0; ko2 = '0;
    plaintext = PT_B; key = K_B; start = 1'b1;
    tick();
    // start stays high; these inputs are only taken at the done edge
    plaintext = PT_C; key = K_C;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done === 1'b1) begin
        if (first < 0) begin
          first = i; ct1 = cipher_text;
        end else begin
          second = i; ct2 = cipher_text; ko2 = keyout;
          break;
        end
      end
    end
    start = 1'b0;
    total++; if (first !== 10) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=10", first); end
    total++; if (second !== 21) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=21", second); end
    total++; if (ct1 !== CT_B) begin bad++; $display("FAIL b2b_ct1 got=%h exp=%h", ct1, CT_B); end
    total++; if (ct2 !== CT_C) begin bad++; $display("FAIL b2b_ct2 got=%h exp=%h", ct2, CT_C); end
    total++; if (ko2 !== KO_C) begin bad++; $display("FAIL b2b_keyout2 got=%h exp=%h", ko2, KO_C); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    plaintext = PT_C; key = K_C; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_high got=%b exp=1", busy); end
    plaintext = PT_B; key = K_B; start = 1'b1;
    tick();
    start = 1'b0; plaintext = '0; key = '0;
    lat = -1;
    for (int i = 5; i <= 25; i++) begin
      tick();
      if (done === 1'b1) begin lat = i; break; end
    end
    total++; if (lat !== 10) begin bad++; $display("FAIL busy_ignore_latency got=%0d exp=10", lat); end
    total++; if (cipher_text !== CT_C) begin bad++; $display("FAIL busy_ignore_ct got=%h exp=%h", cipher_text, CT_C); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_requeue got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct, ko;
    int lat, dones;
    plaintext = PT_B; key = K_B; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    total++; if (cipher_text !== 128'h0) begin bad++; $display("FAIL midrst_ct got=%h exp=0", cipher_text); end
    total++; if (keyout !== 128'h0) begin bad++; $display("FAIL midrst_keyout got=%h exp=0", keyout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    do_block(PT_C, K_C, ct, ko, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL midrst_c1_latency got=%0d exp=10", lat); end
    total++; if (ct !== CT_C) begin bad++; $display("FAIL midrst_c1_ct got=%h exp=%h", ct, CT_C); end
    total++; if (ko !== KO_C) begin bad++; $display("FAIL midrst_c1_keyout got=%h exp=%h", ko, KO_C); end
  endtask

  task automatic test_random();
    logic [127:0] pt, k, prev;
    logic [255:0] m;
    int lat;
    bit unstable;
    prev = cipher_text;
    for (int n = 0; n < 1000; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      if (n % 4 == 3) k = {$urandom_range(255, 0), 120'h0};
      m  = m_enc(pt, k);
      plaintext = pt; key = k; start = 1'b1;
      tick();
      start = 1'b0;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      lat = -1; unstable = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (done === 1'b1) begin lat = i; break; end
        if (cipher_text !== prev) unstable = 1'b1;
      end
      total++; if (unstable) begin bad++; $display("FAIL rnd_stable n=%0d got=%h exp=%h", n, cipher_text, prev); end
      total++; if (lat !== 10) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=10", n, lat); end
      total++; if (cipher_text !== m[255:128]) begin bad++; $display("FAIL rnd_ct n=%0d got=%h exp=%h", n, cipher_text, m[255:128]); end
      total++; if (keyout !== m[127:0]) begin bad++; $display("FAIL rnd_keyout n=%0d got=%h exp=%h", n, keyout, m[127:0]); end
      prev = m[255:128];
    end
  endtask

  initial begin
    test_reset();
    test_app_b();
    test_c1();
    test_zero();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
